// File: rtl/rv32i_cpu_if.sv
// Shared instruction/data memory bus between the rv32i_cpu master and a
// word-wide synchronous RAM clocked on the inverted CPU clock.
interface rv32i_cpu_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_r;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic        bus_write;

  modport master (
    output bus_addr,
    output bus_data_w,
    output bus_mask_w,
    output bus_write,
    input  bus_data_r
  );

  modport slave (
    input  bus_addr,
    input  bus_data_w,
    input  bus_mask_w,
    input  bus_write,
    output bus_data_r
  );
endinterface

// File: rtl/rv32i_cpu.sv
// Multi-cycle RV32I core: FETCH -> EXEC (-> LOAD) over one shared word bus.
// Bus outputs are decoded combinationally from registered state only.
module rv32i_cpu (
  input  logic        clock,
  input  logic        reset,
  rv32i_cpu_if.master bus
);

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_LOAD} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_regs [0:31];
  logic [29:0] r_ld_word;
  logic [1:0]  r_ld_lo;
  logic [2:0]  r_ld_f3;
  logic [4:0]  r_ld_rd;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val, w_ea, w_pc4;

  assign w_opcode  = r_ir[6:0];
  assign w_rd      = r_ir[11:7];
  assign w_f3      = r_ir[14:12];
  assign w_rs1     = r_ir[19:15];
  assign w_rs2     = r_ir[24:20];
  assign w_imm_i   = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s   = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b   = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u   = {r_ir[31:12], 12'b0};
  assign w_imm_j   = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  // x0 is never written, so entry 0 stays at its reset value of zero.
  assign w_rs1_val = r_regs[w_rs1];
  assign w_rs2_val = r_regs[w_rs2];
  assign w_ea      = w_rs1_val + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
  assign w_pc4     = r_pc + 32'd4;

  logic [31:0] w_alu_b, w_alu;
  logic        w_taken;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_alu_b = (w_opcode == OPC_OP) ? w_rs2_val : w_imm_i;
    case (w_f3)
      3'b000:  w_alu = (w_opcode == OPC_OP && r_ir[30]) ? w_rs1_val - w_alu_b
                                                        : w_rs1_val + w_alu_b;
      3'b001:  w_alu = w_rs1_val << w_alu_b[4:0];
      3'b010:  w_alu = {31'b0, $signed(w_rs1_val) < $signed(w_alu_b)};
      3'b011:  w_alu = {31'b0, w_rs1_val < w_alu_b};
      3'b100:  w_alu = w_rs1_val ^ w_alu_b;
      3'b101:  w_alu = r_ir[30] ? 32'($signed(w_rs1_val) >>> w_alu_b[4:0])
                                : w_rs1_val >> w_alu_b[4:0];
      3'b110:  w_alu = w_rs1_val | w_alu_b;
      default: w_alu = w_rs1_val & w_alu_b;
    endcase

    case (w_f3)
      3'b000:  w_taken = (w_rs1_val == w_rs2_val);
      3'b001:  w_taken = (w_rs1_val != w_rs2_val);
      3'b100:  w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'b101:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110:  w_taken = (w_rs1_val <  w_rs2_val);
      3'b111:  w_taken = (w_rs1_val >= w_rs2_val);
      default: w_taken = 1'b0;
    endcase
  end

  logic        w_wb_en;
  logic [31:0] w_wb_data, w_next_pc;

  always_comb begin
    w_wb_en   = 1'b0;
    w_wb_data = w_alu;
    w_next_pc = w_pc4;
    case (w_opcode)
      OPC_LUI:    begin w_wb_en = 1'b1; w_wb_data = w_imm_u; end
      OPC_AUIPC:  begin w_wb_en = 1'b1; w_wb_data = r_pc + w_imm_u; end
      OPC_OPIMM,
      OPC_OP:     w_wb_en = 1'b1;
      OPC_JAL:    begin w_wb_en = 1'b1; w_wb_data = w_pc4; w_next_pc = r_pc + w_imm_j; end
      OPC_JALR:   begin
        w_wb_en   = 1'b1;
        w_wb_data = w_pc4;
        w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
      end
      OPC_BRANCH: w_next_pc = w_taken ? r_pc + w_imm_b : w_pc4;
      default:    ;
    endcase
  end

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  always_comb begin
    case (r_ld_lo)
      2'd0:    w_ld_byte = bus.bus_data_r[7:0];
      2'd1:    w_ld_byte = bus.bus_data_r[15:8];
      2'd2:    w_ld_byte = bus.bus_data_r[23:16];
      default: w_ld_byte = bus.bus_data_r[31:24];
    endcase
    w_ld_half = r_ld_lo[1] ? bus.bus_data_r[31:16] : bus.bus_data_r[15:0];
    case (r_ld_f3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'b0, w_ld_byte};
      3'b101:  w_ld_data = {16'b0, w_ld_half};
      default: w_ld_data = bus.bus_data_r;
    endcase
  end

  always_comb begin
    bus.bus_addr   = {2'b00, r_pc[31:2]};
    bus.bus_write  = 1'b0;
    bus.bus_mask_w = 4'b0000;
    bus.bus_data_w = 32'b0;
    case (r_state)
      ST_EXEC: begin
        if (w_opcode == OPC_LOAD) begin
          bus.bus_addr = {2'b00, w_ea[31:2]};
        end else if (w_opcode == OPC_STORE) begin
          bus.bus_addr = {2'b00, w_ea[31:2]};
          case (w_f3)
            3'b000: begin
              bus.bus_write  = 1'b1;
              bus.bus_data_w = {4{w_rs2_val[7:0]}};
              bus.bus_mask_w = 4'b0001 << w_ea[1:0];
            end
            3'b001: begin
              bus.bus_write  = 1'b1;
              bus.bus_data_w = {2{w_rs2_val[15:0]}};
              bus.bus_mask_w = 4'b0011 << {w_ea[1], 1'b0};
            end
            3'b010: begin
              bus.bus_write  = 1'b1;
              bus.bus_data_w = w_rs2_val;
              bus.bus_mask_w = 4'b1111;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: bus.bus_addr = {2'b00, r_ld_word};
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_ld_word <= '0;
      r_ld_lo   <= '0;
      r_ld_f3   <= '0;
      r_ld_rd   <= '0;
      // NOTE: the register file is flops, not RAM, so it can and must be cleared on reset.
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_ir    <= bus.bus_data_r;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_opcode == OPC_LOAD) begin
            r_ld_word <= w_ea[31:2];
            r_ld_lo   <= w_ea[1:0];
            r_ld_f3   <= w_f3;
            r_ld_rd   <= w_rd;
            r_state   <= ST_LOAD;
          end else begin
            if (w_wb_en && w_rd != 5'd0) r_regs[w_rd] <= w_wb_data;
            r_pc    <= w_next_pc;
            r_state <= ST_FETCH;
          end
        end
        ST_LOAD: begin
          if (r_ld_rd != 5'd0) r_regs[r_ld_rd] <= w_ld_data;
          r_pc    <= w_pc4;
          r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_cpu.sv
// Scoreboarded bench for rv32i_cpu: a directed program runs against a
// negedge-clocked RAM; cycle-stamped bus events are queued and compared.
module tb_rv32i_cpu;

  localparam logic [6:0] LUI = 7'b0110111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011, LD  = 7'b0000011, ST   = 7'b0100011;
  localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011;

  typedef struct packed {
    logic [31:0] cyc;
    logic        wr;
    logic        chk_addr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_prog = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [31:0] prog [0:255];
  logic [31:0] mem  [0:255];

  rv32i_cpu_if bus ();

  rv32i_cpu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // RAM on the inverted clock: read data for this cycle's address is ready by the next rising edge.
  always @(negedge clock) begin
    if (load_prog) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    end else if (bus.bus_write) begin
      for (int k = 0; k < 4; k++)
        if (bus.bus_mask_w[k]) mem[bus.bus_addr[7:0]][8*k +: 8] <= bus.bus_data_w[8*k +: 8];
    end
    bus.bus_data_r <= mem[bus.bus_addr[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("write@%0d", cyc), {31'b0, bus.bus_write}, {31'b0, e.wr});
        if (e.chk_addr) check($sformatf("addr@%0d", cyc), bus.bus_addr, e.addr);
        check($sformatf("data_w@%0d", cyc), bus.bus_data_w, e.data);
        check($sformatf("mask_w@%0d", cyc), {28'b0, bus.bus_mask_w}, {28'b0, e.mask});
      end else if (bus.bus_write) begin
        check($sformatf("unexpected_write@%0d", cyc), {31'b0, bus.bus_write}, 32'd0);
      end
    end
  end

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] m, a, f, d;
    m = imm; a = rs1; f = f3; d = rd;
    return {m[11:0], a[4:0], f[2:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] m, b, a, f;
    m = imm; b = rs2; a = rs1; f = f3;
    return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], ST};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] m, b, a, f;
    m = imm; b = rs2; a = rs1; f = f3;
    return {m[12], m[10:5], b[4:0], a[4:0], f[2:0], m[4:1], m[11], BR};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd);
    logic [31:0] m, d;
    m = imm20; d = rd;
    return {m[19:0], d[4:0], LUI};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] m, d;
    m = imm; d = rd;
    return {m[20], m[10:1], m[11], m[19:12], d[4:0], JAL};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    logic [31:0] s, b, a, f, d;
    s = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], OPR};
  endfunction

  task automatic push_ev(input int c, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    exp_t e;
    e.cyc = 32'(c); e.wr = wr; e.chk_addr = 1'b1; e.addr = a; e.data = d; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [31:0] a);
    push_ev(c, 1'b0, a, 32'h0, 4'h0);
  endtask

  // Hand-derived bus events for one run of the program, stamped by cycles since reset release.
  task automatic push_program_expects();
    push_rd(0, 32'h00);
    push_ev(3, 1'b1, 32'd4, 32'h0000_0005, 4'b1111);
    push_rd(10, 32'h0A);
    push_rd(12, 32'h0B);
    push_ev(13, 1'b1, 32'd4, 32'hABAB_ABAB, 4'b0010);
    push_ev(19, 1'b1, 32'd4, 32'h8080_8080, 4'b1100);
    push_ev(21, 1'b1, 32'd4, 32'h1234_8080, 4'b1111);
    push_rd(24, 32'h20);
    push_rd(25, 32'd4);
    push_rd(26, 32'd4);
    push_ev(28, 1'b1, 32'd128, 32'hFFFF_FF80, 4'b1111);
    push_ev(33, 1'b1, 32'd129, 32'h0000_0080, 4'b1111);
    push_ev(38, 1'b1, 32'd130, 32'h0000_1234, 4'b1111);
    push_ev(43, 1'b1, 32'd131, 32'hFFFF_8080, 4'b1111);
    push_rd(46, 32'h30);
    push_rd(48, 32'h2C);
    push_ev(49, 1'b1, 32'd132, 32'h0000_00C4, 4'b1111);
    push_rd(52, 32'h37);
    push_ev(55, 1'b1, 32'd133, 32'h0000_00E0, 4'b1111);
    push_ev(59, 1'b1, 32'd134, 32'h0000_0000, 4'b1111);
    push_ev(65, 1'b1, 32'd135, 32'hFFFF_FFFF, 4'b1111);
    push_ev(73, 1'b1, 32'd136, 32'hF800_0000, 4'b1111);
    push_ev(77, 1'b1, 32'd137, 32'h0000_0001, 4'b1111);
    push_ev(81, 1'b1, 32'd138, 32'h0000_0000, 4'b1111);
    push_ev(85, 1'b1, 32'd139, 32'h0000_0001, 4'b1111);
    push_rd(88, 32'h49);
    push_rd(90, 32'h4B);
    push_rd(92, 32'h4B);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},   bus.bus_addr,   32'h0);
    check({tag, "_write"},  {31'b0, bus.bus_write}, 32'h0);
    check({tag, "_mask"},   {28'b0, bus.bus_mask_w}, 32'h0);
    check({tag, "_data_w"}, bus.bus_data_w, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = enc_s(12'h3FC, 0, 0, 2);
    prog[0]  = enc_i(5, 0, 0, 1, OPI);                 // addi x1,x0,5
    prog[1]  = enc_s(16, 1, 0, 2);                     // sw   x1,16(x0)
    prog[2]  = enc_i(12'hAB, 0, 0, 2, OPI);            // addi x2,x0,0xAB
    prog[3]  = enc_j(32'h14, 0);                       // jal  x0,0x20
    prog[4]  = 32'h0;                                  // data word
    prog[8]  = enc_b(8, 0, 0, 0);                      // beq  x0,x0,+8
    prog[10] = enc_b(8, 0, 0, 1);                      // bne  x0,x0,+8
    prog[11] = enc_s(17, 2, 0, 0);                     // sb   x2,17(x0)
    prog[12] = enc_u(32'h12348, 5);                    // lui  x5,0x12348
    prog[13] = enc_i(12'h080, 5, 0, 5, OPI);           // addi x5,x5,0x80
    prog[14] = enc_s(18, 5, 0, 1);                     // sh   x5,18(x0)
    prog[15] = enc_s(16, 5, 0, 2);                     // sw   x5,16(x0)
    prog[16] = enc_j(32'h40, 0);                       // jal  x0,0x80
    prog[32] = enc_i(16, 0, 0, 3, LD);                 // lb   x3,16(x0)
    prog[33] = enc_s(12'h200, 3, 0, 2);
    prog[34] = enc_i(16, 0, 4, 4, LD);                 // lbu  x4,16(x0)
    prog[35] = enc_s(12'h204, 4, 0, 2);
    prog[36] = enc_i(18, 0, 1, 3, LD);                 // lh   x3,18(x0)
    prog[37] = enc_s(12'h208, 3, 0, 2);
    prog[38] = enc_i(16, 0, 1, 7, LD);                 // lh   x7,16(x0)
    prog[39] = enc_s(12'h20C, 7, 0, 2);
    prog[40] = enc_j(32'h20, 0);                       // jal  x0,0xC0
    prog[48] = enc_j(-16, 1);                          // 0xC0: jal x1,-16
    prog[44] = enc_s(12'h210, 1, 0, 2);                // 0xB0: sw x1
    prog[45] = enc_i(12'h019, 1, 0, 0, JALR);          // jalr x0,0x19(x1) -> 0xDC
    prog[55] = enc_j(4, 8);                            // 0xDC: jal x8,+4
    prog[56] = enc_s(12'h214, 8, 0, 2);
    prog[57] = enc_i(7, 0, 0, 0, OPI);                 // addi x0,x0,7
    prog[58] = enc_s(12'h218, 0, 0, 2);
    prog[59] = enc_i(1, 0, 0, 9, OPI);                 // addi x9,x0,1
    prog[60] = enc_r(7'h20, 9, 0, 0, 10);              // sub  x10,x0,x9
    prog[61] = enc_s(12'h21C, 10, 0, 2);
    prog[62] = enc_u(32'h80000, 11);                   // lui  x11,0x80000
    prog[63] = enc_i(4, 0, 0, 12, OPI);                // addi x12,x0,4
    prog[64] = enc_r(7'h20, 12, 11, 5, 13);            // sra  x13,x11,x12
    prog[65] = enc_s(12'h220, 13, 0, 2);
    prog[66] = enc_r(0, 10, 9, 3, 14);                 // sltu x14,x9,x10
    prog[67] = enc_s(12'h224, 14, 0, 2);
    prog[68] = enc_r(0, 10, 9, 2, 15);                 // slt  x15,x9,x10
    prog[69] = enc_s(12'h228, 15, 0, 2);
    prog[70] = enc_r(0, 9, 10, 2, 16);                 // slt  x16,x10,x9
    prog[71] = enc_s(12'h22C, 16, 0, 2);
    prog[72] = enc_b(8, 9, 10, 6);                     // bltu x10,x9,+8 (not taken)
    prog[73] = enc_b(8, 9, 10, 4);                     // blt  x10,x9,+8 (taken)
    prog[75] = enc_j(0, 0);                            // 0x12C: jal x0,0

    #1 reset = 1'b1;
    load_prog = 1'b1;
    @(negedge clock);
    #1 load_prog = 1'b0;
    #1 check_reset_outputs("reset_initial");

    push_program_expects();
    @(posedge clock);
    #1 reset = 1'b0;
    #1 check_reset_outputs("after_release");
    repeat (100) @(posedge clock);
    check("pending_run1", 32'(exp_q.size()), 32'd0);

    // Mid-run reset while the core sits in its self-loop.
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check_reset_outputs("reset_midrun");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Let the first store reach EXEC, then reset inside that cycle.
    repeat (3) @(posedge clock);
    #1 check("store_exec_write", {31'b0, bus.bus_write}, 32'd1);
    check("store_exec_addr", bus.bus_addr, 32'd4);
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_in_store");
    @(negedge clock);
    #1 check("withdrawn_store_mem", mem[4], 32'h1234_8080);

    push_program_expects();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (100) @(posedge clock);
    check("pending_run2", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_cpu.md
# rv32i_cpu

Multi-cycle RV32I integer core with a single shared 32-bit memory bus used for both instruction fetch and data access. It sits as the bus master in front of a synchronous word-wide block RAM. The RAM is clocked on the inverted CPU clock, so a read addressed during a CPU cycle returns its data before the next rising edge. Non-load instructions take 2 cycles and loads take 3.

## Interface

Parameters:
- none; reset PC is fixed at 0.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `bus_addr`  out  32  word address: byte address bits [31:2], zero-extended, so bit 31..30 are 0.
- `bus_data_r`  in  32  read data for the word addressed in the current cycle; valid at the next rising edge.
- `bus_data_w`  out  32  write data, lane-aligned; byte lane k is bits [8k+7:8k].
- `bus_mask_w`  out  4  byte-lane enables, meaningful only when `bus_write`=1.
- `bus_write`  out  1  write strobe; memory commits the enabled lanes in the cycle it is high.

## Operation

- **State.**
  - 32-bit `pc`.
  - 32-bit instruction register `ir`.
  - 31 general registers x1..x31; x0 reads 0 and writes to it are discarded.
  - FSM state.
- **States:** FETCH, EXEC, LOAD.
- **FETCH.**
  - Drive `bus_addr`=`pc`[31:2] and `bus_write`=0.
  - At the rising edge, capture `ir`←`bus_data_r` and go to EXEC.
- **EXEC.** Decode `ir` and execute it.
  - **ALU ops:** LUI, AUIPC, OP-IMM (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI) and OP (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND).
    - Write rd, set `pc`←`pc`+4, go to FETCH.
    - Shift amount is the low 5 bits; SLT is signed and SLTU unsigned.
  - **JAL / JALR:**
    - rd←`pc`+4.
    - JAL: `pc`←`pc`+imm.
    - JALR: `pc`←(rs1+imm)&~1.
    - Go to FETCH.
  - **BEQ/BNE/BLT/BGE/BLTU/BGEU:**
    - Taken: `pc`←`pc`+imm; otherwise `pc`←`pc`+4.
    - Go to FETCH.
  - **Store (SB/SH/SW):**
    - ea=rs1+imm; drive `bus_addr`=ea[31:2] and `bus_write`=1.
    - `bus_data_w`=rs2 replicated per lane: SB→{4{rs2[7:0]}}, SH→{2{rs2[15:0]}}, SW→rs2.
    - `bus_mask_w`: SB=0001<<ea[1:0], SH=0011<<(2·ea[1]), SW=1111.
    - Set `pc`←`pc`+4, go to FETCH.
  - **Load (LB/LH/LW/LBU/LHU):**
    - ea=rs1+imm; drive `bus_addr`=ea[31:2] and `bus_write`=0.
    - Latch ea[1:0], funct3 and rd; go to LOAD.
  - **FENCE, ECALL, EBREAK, CSR and any undefined opcode:** no-op with `pc`←`pc`+4.
- **LOAD.**
  - Hold `bus_addr`=ea[31:2].
  - At the rising edge, select the lane from `bus_data_r`: byte by ea[1:0], half by ea[1], word ignores ea[1:0].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; write rd, set `pc`←`pc`+4, go to FETCH.
- **Misalignment.**
  - Low address bits that do not select a lane are ignored; no trap is raised.
  - Branch and jump targets use bits [31:2] for fetch.
- **Output defaults.** In every state other than a store EXEC, `bus_write`=0, `bus_mask_w`=0000 and `bus_data_w`=0.

## Timing

- **Reset (asynchronous).** `pc`=0, state=FETCH, `ir`=0 and all registers 0.
  - Outputs during and immediately after reset: `bus_addr`=0, `bus_write`=0, `bus_mask_w`=0, `bus_data_w`=0.
- **First fetch.** The first rising edge after reset deasserts captures the word at address 0.
- **Reset mid-operation.** Asserting reset in any state, including a store EXEC, forces the outputs to reset values within the same cycle. A write strobe in progress is withdrawn.
- **Bus outputs.** All bus outputs are combinational from registered state only (`pc`, `ir`, FSM state and the register file). They are stable by the falling edge, where the memory samples them.
- **Latency.**
  - 2 cycles for every non-load instruction.
  - 3 cycles for loads.
  - A store's write occurs during its EXEC cycle.
- **Register file.** Reads are combinational. A write lands at the end of EXEC or LOAD, so the next instruction always sees it and no forwarding is needed.

## Test plan

- **Reset:** assert reset mid-run, release → `bus_addr`=0, `bus_write`=0; the next two edges fetch word 0 then execute it.
- **ALU + store:** `addi x1,x0,5` then `sw x1,16(x0)` → in the store EXEC cycle `bus_write`=1, `bus_addr`=4, `bus_data_w`=0x00000005, `bus_mask_w`=1111.
- **Byte store:**
  - x2=0xAB; `sb x2,17(x0)` → `bus_addr`=4, `bus_mask_w`=0010, `bus_data_w`=0xABABABAB.
  - `sh` to offset 2 → `bus_mask_w`=1100.
- **Loads:** word 4 = 0x12348080.
  - `lb x3,16(x0)` → x3=0xFFFFFF80.
  - `lbu` → 0x00000080.
  - `lh x3,18(x0)` → 0x00001234.
  - Each load takes 3 cycles.
- **Control flow:**
  - `beq` taken with imm=+8 at pc=0x20 → next fetch `bus_addr`=0x0A.
  - Not taken → 0x09.
  - `jal x1,-16` at 0x40 → x1=0x44, fetch at 0x0C.
  - `jalr` clears bit 0.
- **x0 and arithmetic:**
  - `addi x0,x0,7` leaves x0=0.
  - `sub` with 0−1 gives 0xFFFFFFFF.
  - `sra` of 0x80000000 by 4 gives 0xF8000000.
  - `sltu` of 1 < 0xFFFFFFFF gives 1, while `slt` on the same operands gives 0.
